// File: rtl/uart_pkg.sv
// Shared UART types, oversampling constants and small helpers for the receive and transmit paths.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   localparam int unsigned OVERSAMPLE = 16;

   // Mid-bit sample points and the tick at which each bit's vote is acted on.
   localparam logic [3:0] SAMPLE_TICK_A = 4'd7;
   localparam logic [3:0] SAMPLE_TICK_B = 4'd8;
   localparam logic [3:0] SAMPLE_TICK_C = 4'd9;
   localparam logic [3:0] DECIDE_TICK   = 4'd9;
   localparam logic [3:0] LAST_TICK     = 4'd15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: counts 0..DIV-1 and emits a registered one-cycle tick at DIV-1.
// A synchronous clear restarts the count so ticks can be phase-aligned to an external event.
module uart_baud_tick #(
   parameter int unsigned DIV = 54
)(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_nxt_s;
   logic          tick_r;

   // Next count: clear wins, otherwise wrap at the last count.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (clr) begin
         cnt_nxt_s = {CW{1'b0}};
      end else if (cnt_r == LAST_CNT) begin
         cnt_nxt_s = {CW{1'b0}};
      end else begin
         cnt_nxt_s = cnt_r + CW'(1'b1);
      end
   end

   // Count register; tick is registered so it is high exactly while the count sits at DIV-1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nxt_s;
         tick_r <= (cnt_nxt_s == LAST_CNT);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_rx_framer.sv
// RS-232 receiver: 16x oversampling, 3-sample majority vote, start/stop validation, byte strobe.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking; otherwise 8N1.
module uart_rx_framer
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115200
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       rs232_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_parity_err,
   output logic       rx_busy
);

   localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AFTER_DATA = PARITY;
`else
   localparam rx_state_t AFTER_DATA = STOP;
`endif

   logic       sync1_r, sync2_r, prev_r;
   logic       fall_s, tick_s, clr_s, vote_s;
   rx_state_t  state_r, state_nxt_s;
   logic [3:0] tick_cnt_r, tick_cnt_nxt_s;
   logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
   logic [7:0] shift_r, shift_nxt_s;
   logic       s7_r, s7_nxt_s, s8_r, s8_nxt_s;
   logic [7:0] data_r, data_nxt_s;
   logic       valid_r, valid_nxt_s;
   logic       ferr_r, ferr_nxt_s;
   logic       busy_r;
`ifdef UART_RX_PARITY_EN
   logic       par_mis_r, par_mis_nxt_s;
   logic       perr_r, perr_nxt_s;
`endif

   // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle level is 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
      end else begin
         sync1_r <= rs232_rx;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign fall_s = prev_r & ~sync2_r;
   assign vote_s = majority3(s7_r, s8_r, sync2_r);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_s),
      .tick  (tick_s)
   );

   // Next-state and datapath decisions; the third vote sample is the live line at tick 9.
   always_comb begin
      state_nxt_s    = state_r;
      tick_cnt_nxt_s = tick_cnt_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      shift_nxt_s    = shift_r;
      data_nxt_s     = data_r;
      valid_nxt_s    = 1'b0;
      ferr_nxt_s     = 1'b0;
      clr_s          = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_mis_nxt_s  = par_mis_r;
      perr_nxt_s     = 1'b0;
`endif
      if (tick_s && (tick_cnt_r == SAMPLE_TICK_A)) begin
         s7_nxt_s = sync2_r;
      end else begin
         s7_nxt_s = s7_r;
      end
      if (tick_s && (tick_cnt_r == SAMPLE_TICK_B)) begin
         s8_nxt_s = sync2_r;
      end else begin
         s8_nxt_s = s8_r;
      end

      case (state_r)
         IDLE: begin
            if (fall_s) begin
               state_nxt_s    = START;
               tick_cnt_nxt_s = 4'd0;
               bit_cnt_nxt_s  = 3'd0;
               clr_s          = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               if ((tick_cnt_r == SAMPLE_TICK_C) && vote_s) begin
                  state_nxt_s    = IDLE;
                  tick_cnt_nxt_s = 4'd0;
               end else if (tick_cnt_r == LAST_TICK) begin
                  state_nxt_s = DATA;
               end else begin
                  state_nxt_s = START;
               end
            end else begin
               state_nxt_s = START;
            end
         end
         DATA: begin
            if (tick_s) begin
               tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               if (tick_cnt_r == DECIDE_TICK) begin
                  shift_nxt_s = {vote_s, shift_r[7:1]};
               end else if (tick_cnt_r == LAST_TICK) begin
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                  if (bit_cnt_r == 3'd7) begin
                     state_nxt_s = AFTER_DATA;
                  end else begin
                     state_nxt_s = DATA;
                  end
               end else begin
                  shift_nxt_s = shift_r;
               end
            end else begin
               shift_nxt_s = shift_r;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_s) begin
               tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               if (tick_cnt_r == DECIDE_TICK) begin
                  par_mis_nxt_s = vote_s ^ even_parity(shift_r);
               end else if (tick_cnt_r == LAST_TICK) begin
                  state_nxt_s = STOP;
               end else begin
                  state_nxt_s = PARITY;
               end
            end else begin
               state_nxt_s = PARITY;
            end
         end
`endif
         STOP: begin
            if (tick_s) begin
               tick_cnt_nxt_s = tick_cnt_r + 4'd1;
               if (tick_cnt_r == DECIDE_TICK) begin
                  tick_cnt_nxt_s = 4'd0;
                  if (!vote_s) begin
                     ferr_nxt_s  = 1'b1;
                     state_nxt_s = BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (par_mis_r) begin
                     perr_nxt_s  = 1'b1;
                     state_nxt_s = IDLE;
`endif
                  end else begin
                     data_nxt_s  = shift_r;
                     valid_nxt_s = 1'b1;
                     state_nxt_s = IDLE;
                  end
               end else begin
                  state_nxt_s = STOP;
               end
            end else begin
               state_nxt_s = STOP;
            end
         end
         BREAK: begin
            // A line held low must return high before another start is accepted.
            if (sync2_r) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = BREAK;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         tick_cnt_r <= 4'd0;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'h00;
         s7_r       <= 1'b1;
         s8_r       <= 1'b1;
         data_r     <= 8'h00;
         valid_r    <= 1'b0;
         ferr_r     <= 1'b0;
         busy_r     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_mis_r  <= 1'b0;
         perr_r     <= 1'b0;
`endif
      end else begin
         state_r    <= state_nxt_s;
         tick_cnt_r <= tick_cnt_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         shift_r    <= shift_nxt_s;
         s7_r       <= s7_nxt_s;
         s8_r       <= s8_nxt_s;
         data_r     <= data_nxt_s;
         valid_r    <= valid_nxt_s;
         ferr_r     <= ferr_nxt_s;
         busy_r     <= (state_nxt_s != IDLE);
`ifdef UART_RX_PARITY_EN
         par_mis_r  <= par_mis_nxt_s;
         perr_r     <= perr_nxt_s;
`endif
      end
   end

   assign rx_data      = data_r;
   assign rx_valid     = valid_r;
   assign rx_frame_err = ferr_r;
   assign rx_busy      = busy_r;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err = perr_r;
`else
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

RS-232 receive front end for the board's serial path. Oversamples the asynchronous `rs232_rx` pin at 16× baud, validates start and stop bits, and delivers each received byte as an 8-bit word with a one-cycle strobe. Sits directly upstream of the loopback/recorder logic, which consumes `rx_data` on `rx_valid`.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `rs232_rx`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_data`  out  8  last good byte, LSB received first; held until the next good byte.
- `rx_valid`  out  1  one-cycle strobe; `rx_data` is new this cycle.
- `rx_frame_err`  out  1  one-cycle strobe; stop bit sampled low.
- `rx_parity_err`  out  1  one-cycle strobe; parity mismatch (tied 0 when parity is compiled out).
- `rx_busy`  out  1  high while in any state other than IDLE.

## Operation
- `rs232_rx` passes through a 2-flop synchronizer, reset to 1. Falling-edge detection uses the synchronized value.
- Tick divider: `DIV = CLK_FREQ/(BAUD*16)`, integer truncation; 54 at the defaults. The counter runs 0..DIV-1 and emits `tick` at DIV-1. It is cleared on the start edge in IDLE so that ticks are phase-aligned to the frame.
- Each bit spans 16 ticks, numbered 0..15. The bit value is the majority vote of the samples at ticks 7, 8 and 9.
- States:
  - **IDLE**: on a synchronized falling edge → START.
  - **START**: at tick 9, if the vote is 1 (glitch) → IDLE with no strobes; otherwise at tick 15 → DATA.
  - **DATA**: 8 bits, shifted in LSB first; after bit 7 → PARITY if enabled, else STOP.
  - **PARITY**: vote compared against even parity of the data byte.
  - **STOP**: decision at tick 9.
    - Vote 1 and no parity error: `rx_data` loads and `rx_valid` pulses → IDLE.
    - Vote 0: `rx_frame_err` pulses, `rx_data` is unchanged → BREAK.
    - Parity error with a good stop: `rx_parity_err` pulses, `rx_data` is unchanged → IDLE.
  - **BREAK**: waits until the synchronized line is 1 → IDLE. This prevents a held-low line from re-triggering a start.
- At most one of the three strobes fires per frame.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `rx_frame_err`=0, `rx_parity_err`=0, `rx_busy`=0. State is IDLE and all counters are 0.
- Reset asserted mid-frame aborts the frame with no strobe. After release, the block waits in IDLE for a fresh falling edge.
- Latency from the line's start edge to `rx_valid`:
  - without parity: 2 sync cycles + (9×16+9+1)×DIV clk = 8318 clk at the defaults.
  - with parity: add 16×DIV = 864 clk.
- Decisions are made at mid-stop, so a new start edge can be accepted as early as 6 ticks later. Back-to-back frames with a full stop bit are received without loss.
- `rx_busy` rises in the cycle after the start edge is detected and falls in the cycle the strobe fires (or when BREAK exits).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The frame is 8E1, and the PARITY state exists.
  - Even parity is checked, and a mismatch drives `rx_parity_err`.
- Undefined:
  - The frame is 8N1, and the PARITY state is absent.
  - `rx_parity_err` is constant 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `OVERSAMPLE`=16;
  - the sample-tick constants 7/8/9 and the decision tick 9.
- Sub-module `uart_baud_tick`: parameterized divider with a synchronous clear input and a `tick` output. It is reused later by the transmit side.
- The synchronizer, vote logic and FSM live in `uart_rx_framer`.

## Test plan
- **Good frame**: send 0x55 as 8N1 at 8640 ns/bit → exactly one `rx_valid` with `rx_data`=0x55; no error strobes; `rx_busy` is low afterwards.
- **Glitch**: line low for 2 µs, then high → no strobes, `rx_busy` returns to 0 by tick 10, and `rx_data` is unchanged.
- **Framing error**: send 0x3C with stop=0, hold the line low for 3 bit times, release, then send 0xA3 → one `rx_frame_err`, `rx_data` stays 0x55, then `rx_valid` fires with 0xA3.
- **Back-to-back**: send 0x00, 0xFF and 0x81 with no idle gap → three `rx_valid` pulses in order, each 864×10 clk apart.
- **Reset mid-frame**: assert `reset` during bit 4 of 0x5A → outputs return to their reset values immediately. The next frame, 0x12, is received correctly.
- **Parity (with `UART_RX_PARITY_EN`)**:
  - send 0x07 with parity bit 1 → `rx_valid` with 0x07;
  - send 0x07 with parity bit 0 → `rx_parity_err` and no `rx_valid`.
